// File: rtl/toggle_dec_pkg.sv
// Shared defaults and helpers for the toggle-event decoder and its clock-crossing helpers.
package toggle_dec_pkg;

  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned CNT_W_DEF       = 4;
  localparam int unsigned MAX_PENDING_DEF = 15;
  localparam int unsigned FILT_CYCLES_DEF = 3;

  // Bits needed to hold values 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// N-flop synchroniser for an asynchronous single-bit input; flops reset to 0.
module sync_chain #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] flops_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flops_q <= '0;
    end else begin
      flops_q <= {flops_q[STAGES-2:0], d};
    end
  end

  assign q = flops_q[STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Turns each level change on an asynchronous toggle line into a queued event with valid/ready.
// Optional stability filter enabled by defining TOGGLE_DEC_GLITCH_FILTER_EN.
module toggle_event_decoder
  import toggle_dec_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned MAX_PENDING = MAX_PENDING_DEF,
  parameter int unsigned FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tog_in,
  output logic             evt_pulse,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] pending,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_PENDING);

  logic             s_out;
  logic             ref_q;
  logic             edge_acc;
  logic             evt_pulse_q;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             overflow_q, overflow_d;
  logic             inc, dec, at_max;

  sync_chain #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .d    (tog_in),
    .q    (s_out)
  );

`ifdef TOGGLE_DEC_GLITCH_FILTER_EN
  localparam int unsigned FiltW = cnt_width(FILT_CYCLES);

  logic [FiltW-1:0] filt_q;
  logic             differ;

  assign differ   = (s_out != ref_q);
  // Accept on the FILT_CYCLES-th consecutive cycle of difference.
  assign edge_acc = differ && (filt_q == FiltW'(FILT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      filt_q <= '0;
    end else if (!differ || edge_acc) begin
      filt_q <= '0;
    end else begin
      filt_q <= filt_q + 1'b1;
    end
  end
`else
  logic unused_filt_cfg;

  assign unused_filt_cfg = |FILT_CYCLES;
  assign edge_acc        = (s_out != ref_q);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ref_q       <= 1'b0;
      evt_pulse_q <= 1'b0;
    end else begin
      if (edge_acc) begin
        ref_q <= s_out;
      end
      evt_pulse_q <= edge_acc;
    end
  end

  assign inc    = evt_pulse_q;
  assign dec    = evt_valid & evt_ready;
  assign at_max = (pending_q == MaxCnt);

  always_comb begin
    pending_d  = pending_q;
    overflow_d = overflow_q;
    if (inc && !dec) begin
      if (at_max) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (dec && !inc) begin
      pending_d = pending_q - 1'b1;
    end
    // A new loss takes priority over a clear in the same cycle.
    if (ovf_clr && !(inc && !dec && at_max)) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      overflow_q <= overflow_d;
    end
  end

  assign evt_pulse = evt_pulse_q;
  assign evt_valid = (pending_q != '0);
  assign pending   = pending_q;
  assign overflow  = overflow_q;

endmodule

// File: doc/toggle_event_decoder.md
Name: toggle_event_decoder

Overview:
- Receiving end of the toggle-encoded event link. The transmitter is a toggle flip-flop that inverts its output once per event.
- Synchronises the toggle line, detects each level change and converts it into a one-cycle event pulse.
- Queues detected events in a saturating pending counter and hands them to the consumer over a valid/ready handshake.
- Sits between the timer's toggle encoders (tick/lap sources) and the display/control logic.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on tog_in; legal range 2..4.
- CNT_W, 4, width of the pending-event counter.
- MAX_PENDING, 15, saturation value of the pending counter; must be ≤ 2^CNT_W−1 and ≥ 1.
- FILT_CYCLES, 3, stability window in cycles; used only with the optional filter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- tog_in  input  1  toggle-encoded event line from the remote encoder; asynchronous to clk.
- evt_pulse  output  1  one-cycle pulse per detected toggle.
- evt_valid  output  1  at least one event is pending.
- evt_ready  input  1  consumer accepts one event when evt_valid=1.
- pending  output  CNT_W  current pending-event count.
- overflow  output  1  sticky flag: an event was lost because the counter was saturated.
- ovf_clr  input  1  synchronous clear of overflow.

Behaviour:
- Reset (reset=0, asynchronous): the following registers are 0: synchroniser flops, reference level, evt_pulse, pending, overflow. evt_valid=0. Reference level 0 matches the encoder's reset level.
- Synchroniser: tog_in passes through SYNC_STAGES flops. Call the last flop's output s_out.
- Edge detect: edge = (s_out != ref). On edge, ref <= s_out and evt_pulse <= 1 for exactly one cycle. Otherwise evt_pulse <= 0.
- Rising and falling transitions each count as one event.
- Latency: tog_in changes before clk edge k and meets setup. Then evt_pulse is high during the cycle after edge k+SYNC_STAGES. pending reflects the event one cycle later than that.
- Transmitter rule: toggles must be spaced by at least SYNC_STAGES+1 clk cycles. A closer double toggle may cancel out and is not detected; this is not an error.
- Pending counter, updated each cycle:
  - inc = evt_pulse.
  - dec = evt_valid & evt_ready.
  - inc & !dec: pending+1 if pending < MAX_PENDING. Else pending holds and overflow <= 1.
  - dec & !inc: pending−1.
  - inc & dec: pending unchanged, no overflow, including at MAX_PENDING.
  - evt_ready while evt_valid=0: ignored, pending stays 0.
- evt_valid = (pending != 0), decoded from the registered count with no extra latency.
- Handshake: evt_valid stays high until pending reaches 0. The consumer may hold evt_ready high continuously and then drains one event per cycle.
- overflow: set as above and cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: all state clears immediately and pending events are discarded. On release, ref=0.
  - If tog_in is 1 at release, one spurious event is reported after the synchroniser latency.
  - The system must therefore reset the encoder and decoder together.

Optional Feature:
- Macro: TOGGLE_DEC_GLITCH_FILTER_EN.
- Defined: a filter counter (reset 0) sits between s_out and the edge detector.
  - An edge is accepted only once s_out has differed from ref for FILT_CYCLES consecutive cycles.
  - The counter resets to 0 whenever s_out == ref.
  - This adds FILT_CYCLES−1 cycles to the latency.
  - The minimum toggle spacing rises to SYNC_STAGES+FILT_CYCLES+1 cycles.
- Not defined: filter logic is absent, latency is as stated above, and FILT_CYCLES is unused.

Decomposition:
- Package toggle_dec_pkg holds: default constants (SYNC_STAGES_DEF=2, CNT_W_DEF=4, MAX_PENDING_DEF=15, FILT_CYCLES_DEF=3) and a function for the counter width needed to hold MAX_PENDING.
- One sub-module, sync_chain: a parameterised N-flop synchroniser with async active-low reset to 0. It is reused by other clock-crossing inputs in the timer.
- Edge detect, filter, counter and flag stay in the top module.

Test Plan:
- Reset/idle: hold reset=0 for 3 cycles with tog_in=0, then release. Required: evt_pulse=0, pending=0, evt_valid=0 and overflow=0 for 20 cycles.
- Single event latency: with SYNC_STAGES=2, drive tog_in 0→1 before edge k. Required: evt_pulse=1 in the cycle after edge k+2 only, pending=1 one cycle later, evt_valid=1. Assert evt_ready for 1 cycle: pending=0, evt_valid=0.
- Burst, no consumer: 5 toggles spaced 4 cycles apart with evt_ready=0. Required: pending=5. Then hold evt_ready=1: pending goes 4,3,2,1,0 on consecutive cycles.
- Saturation: 16 toggles with evt_ready=0 and MAX_PENDING=15. Required: pending=15 and overflow=1. ovf_clr pulsed coincident with a 17th saturating event: overflow stays 1. Next ovf_clr alone: overflow=0.
- Simultaneous inc/dec at max: pending=15, evt_ready=1 in the same cycle evt_pulse=1. Required: pending stays 15, overflow unchanged.
- Filter (macro defined, FILT_CYCLES=3): a 2-cycle glitch on tog_in produces no evt_pulse. A held toggle produces evt_pulse 2 cycles later than in the unfiltered build.
